// File: rtl/xoodyak_pkg.sv
// Shared constants, state encoding and op legality helpers for the Xoodyak
// command sequencer.
package xoodyak_pkg;

    localparam int XD_DATA_W = 352;
    localparam int CONT_BIT  = 4;
    localparam int OP_W      = 5;
    localparam int ENTRY_W   = OP_W + XD_DATA_W;

    localparam logic [3:0] OP_IDLE       = 4'd0;
    localparam logic [3:0] OP_INITIALIZE = 4'd1;
    localparam logic [3:0] OP_NONCE      = 4'd2;
    localparam logic [3:0] OP_ASSOC      = 4'd3;
    localparam logic [3:0] OP_CRYPT      = 4'd4;
    localparam logic [3:0] OP_DECRYPT    = 4'd5;
    localparam logic [3:0] OP_SQUEEZE    = 4'd6;
    localparam logic [3:0] OP_RATCHET    = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } seq_state_e;

    // Ops that only make sense once the core has been initialized.
    function automatic logic op_needs_key(input logic [3:0] code);
        return (code == OP_NONCE) || (code == OP_CRYPT) ||
               (code == OP_DECRYPT) || (code == OP_RATCHET);
    endfunction

    function automatic logic op_legal(input logic [3:0] code, input logic keyed);
        if (code > OP_RATCHET) return 1'b0;
        if (op_needs_key(code) && !keyed) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/xoodyak_cmd_fifo.sv
// Synchronous command FIFO; push is ignored when full and pop when empty.
module xoodyak_cmd_fifo
    import xoodyak_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/xoodyak_cmd_seq.sv
// Buffers Xoodyak operations and issues them one at a time to the core,
// holding opmode/input_data until finished, with timeout and ordering guards.
module xoodyak_cmd_seq
    import xoodyak_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   eph1,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OP_W-1:0]        cmd_op,
    input  logic [XD_DATA_W-1:0]   cmd_data,
    output logic [OP_W-1:0]        opmode,
    output logic [XD_DATA_W-1:0]   input_data,
    input  logic                   finished,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   err_illegal,
    output logic [$clog2(DEPTH):0] level,
    output seq_state_e             dbg_state
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    // Handshake: a command transfers on any edge where cmd_valid && cmd_ready.
    // cmd_ready is simply !full; a same-cycle pop does not open a slot.
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic [OP_W-1:0]      head_op;
    logic [XD_DATA_W-1:0] head_data;

    assign cmd_ready = !fifo_full;
    assign head_op   = fifo_rdata[ENTRY_W-1 -: OP_W];
    assign head_data = fifo_rdata[XD_DATA_W-1:0];

    xoodyak_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (eph1),
        .reset (reset),
        .push  (cmd_valid && cmd_ready),
        .pop   (fifo_pop),
        .wdata ({cmd_op, cmd_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    seq_state_e           state, state_n;
    logic [OP_W-1:0]      opmode_n;
    logic [XD_DATA_W-1:0] input_data_n;
    logic                 keyed, keyed_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 err_timeout_n;
    logic                 err_illegal_n;

    always_ff @(posedge eph1) begin
        if (reset) begin
            state       <= ST_IDLE;
            opmode      <= '0;
            input_data  <= '0;
            keyed       <= 1'b0;
            cnt         <= '0;
            err_timeout <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state       <= state_n;
            opmode      <= opmode_n;
            input_data  <= input_data_n;
            keyed       <= keyed_n;
            cnt         <= cnt_n;
            err_timeout <= err_timeout_n;
            err_illegal <= err_illegal_n;
        end
    end

    always_comb begin
        state_n       = state;
        opmode_n      = opmode;
        input_data_n  = input_data;
        keyed_n       = keyed;
        cnt_n         = cnt;
        err_timeout_n = err_timeout;
        err_illegal_n = 1'b0;
        fifo_pop      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    // Op 0 is a silent no-op regardless of the continue bit.
                    if (head_op[3:0] == OP_IDLE) begin
                        state_n = ST_IDLE;
                    end else if (op_legal(head_op[3:0], keyed)) begin
                        opmode_n     = head_op;
                        input_data_n = head_data;
                        state_n      = ST_ISSUE;
                        if (head_op[3:0] == OP_INITIALIZE) keyed_n = 1'b1;
                    end else begin
                        err_illegal_n = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_n   = '0;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_n = cnt + CW'(1);
                // finished takes priority over a coincident timeout.
                if (finished) begin
                    opmode_n     = '0;
                    input_data_n = '0;
                    state_n      = ST_GAP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    err_timeout_n = 1'b1;
                    opmode_n      = '0;
                    input_data_n  = '0;
                    state_n       = ST_GAP;
                end
            end
            ST_GAP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state == ST_ISSUE) || (state == ST_WAIT);
    assign dbg_state = state;

endmodule

// File: tb/tb_xoodyak_cmd_seq.sv
// Directed bench for xoodyak_cmd_seq: issue latency, ordering, legality,
// timeout, data stability and reset abort.
module tb_xoodyak_cmd_seq;
    import xoodyak_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    localparam logic [351:0] D_INIT = {128'h38393a3b3c3d3e3f3031323334353637, 224'h0};
    localparam logic [351:0] D_CONT = {11{32'ha5c30f17}};
    localparam logic [351:0] D_A    = {32'hdeadbeef, 320'h0};

    logic         eph1 = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [4:0]   cmd_op = '0;
    logic [351:0] cmd_data = '0;
    logic         finished = 1'b0;
    logic         cmd_ready;
    logic [4:0]   opmode;
    logic [351:0] input_data;
    logic         busy;
    logic         err_timeout;
    logic         err_illegal;
    logic [2:0]   level;
    seq_state_e   dbg_state;

    int checks = 0;
    int errors = 0;

    xoodyak_cmd_seq #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .eph1        (eph1),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .opmode      (opmode),
        .input_data  (input_data),
        .finished    (finished),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_illegal (err_illegal),
        .level       (level),
        .dbg_state   (dbg_state)
    );

    always #5 eph1 = ~eph1;

    task tick;
        @(posedge eph1);
        #1;
    endtask

    task do_reset;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        finished  = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // Presents one command for exactly one sampling edge.
    task push(input logic [4:0] op, input logic [351:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        tick;
        cmd_valid = 1'b0;
    endtask

    task test_reset;
        do_reset;
        checks++; if (opmode !== 5'd0) begin errors++; $display("FAIL reset_opmode: got %h expected 00", opmode); end
        checks++; if (input_data !== 352'd0) begin errors++; $display("FAIL reset_input_data: got %h expected 0", input_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout: got %b expected 0", err_timeout); end
        checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err_illegal: got %b expected 0", err_illegal); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task test_basic;
        do_reset;
        push(5'h01, D_INIT);
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL basic_level_push: got %0d expected 1", level); end
        checks++; if (opmode !== 5'd0) begin errors++; $display("FAIL basic_opmode_early: got %h expected 00", opmode); end
        tick;
        checks++; if (opmode !== 5'h01) begin errors++; $display("FAIL basic_opmode: got %h expected 01", opmode); end
        checks++; if (input_data !== D_INIT) begin errors++; $display("FAIL basic_input_data: got %h expected %h", input_data, D_INIT); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL basic_level_pop: got %0d expected 0", level); end
        checks++; if (dbg_state !== ST_ISSUE) begin errors++; $display("FAIL basic_state_issue: got %0d expected %0d", dbg_state, ST_ISSUE); end
        tick;
        checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL basic_state_wait: got %0d expected %0d", dbg_state, ST_WAIT); end
        repeat (11) tick;
        checks++; if (busy !== 1'b1 || opmode !== 5'h01) begin errors++; $display("FAIL basic_hold: busy %b opmode %h expected 1 01", busy, opmode); end
        finished = 1'b1;
        tick;
        finished = 1'b0;
        checks++; if (opmode !== 5'd0) begin errors++; $display("FAIL basic_opmode_done: got %h expected 00", opmode); end
        checks++; if (input_data !== 352'd0) begin errors++; $display("FAIL basic_data_done: got %h expected 0", input_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL basic_no_timeout: got %b expected 0", err_timeout); end
        tick;
        checks++; if (dbg_state !== ST_IDLE || opmode !== 5'd0) begin errors++; $display("FAIL basic_gap: state %0d opmode %h expected %0d 00", dbg_state, opmode, ST_IDLE); end
    endtask

    task test_back_to_back;
        do_reset;
        // Keep the sequencer occupied so the four pushes fill the FIFO.
        push(5'h03, D_A);
        tick;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_op   = 5'(i + 1);
            cmd_data = {344'h0, 8'(i + 1)};
            tick;
            if (i == 2) begin
                checks++; if (cmd_ready !== 1'b1 || level !== 3'd3) begin errors++; $display("FAIL b2b_third: ready %b level %0d expected 1 3", cmd_ready, level); end
            end
        end
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b expected 0", cmd_ready); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_level_full: got %0d expected 4", level); end
        finished = 1'b1;
        tick;
        finished = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (opmode !== 5'd0) begin errors++; $display("FAIL b2b_zero_m_%0d: got %h expected 00", k, opmode); end
            tick;
            checks++; if (opmode !== 5'd0) begin errors++; $display("FAIL b2b_zero_m1_%0d: got %h expected 00", k, opmode); end
            tick;
            checks++; if (opmode !== 5'(k)) begin errors++; $display("FAIL b2b_order_%0d: got %h expected %h", k, opmode, 5'(k)); end
            checks++; if (input_data !== {344'h0, 8'(k)}) begin errors++; $display("FAIL b2b_data_%0d: got %h expected %0d", k, input_data, k); end
            if (k == 1) begin
                checks++; if (cmd_ready !== 1'b1 || level !== 3'd3) begin errors++; $display("FAIL b2b_drain: ready %b level %0d expected 1 3", cmd_ready, level); end
            end
            tick;
            finished = 1'b1;
            tick;
            finished = 1'b0;
        end
        tick;
        tick;
        checks++; if (level !== 3'd0 || opmode !== 5'd0 || err_illegal !== 1'b0) begin errors++; $display("FAIL b2b_end: level %0d opmode %h illegal %b expected 0 00 0", level, opmode, err_illegal); end
    endtask

    task test_illegal;
        do_reset;
        cmd_valid = 1'b1;
        cmd_op    = 5'h04;
        cmd_data  = D_A;
        tick;
        cmd_op    = 5'h03;
        tick;
        cmd_valid = 1'b0;
        checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got %b expected 1", err_illegal); end
        checks++; if (opmode !== 5'd0) begin errors++; $display("FAIL illegal_opmode: got %h expected 00", opmode); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL illegal_level: got %0d expected 1", level); end
        tick;
        checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL illegal_once: got %b expected 0", err_illegal); end
        checks++; if (opmode !== 5'h03) begin errors++; $display("FAIL illegal_next_op: got %h expected 03", opmode); end
        tick;
        finished = 1'b1;
        tick;
        finished = 1'b0;
        tick;
        push(5'h00, D_A);
        tick;
        checks++; if (err_illegal !== 1'b0 || opmode !== 5'd0 || level !== 3'd0) begin errors++; $display("FAIL noop_drop: illegal %b opmode %h level %0d expected 0 00 0", err_illegal, opmode, level); end
        push(5'h0a, D_A);
        tick;
        checks++; if (err_illegal !== 1'b1 || opmode !== 5'd0) begin errors++; $display("FAIL code10_illegal: illegal %b opmode %h expected 1 00", err_illegal, opmode); end
    endtask

    task test_timeout;
        do_reset;
        push(5'h03, D_A);
        tick;
        tick;
        repeat (TIMEOUT - 1) tick;
        checks++; if (err_timeout !== 1'b0 || opmode !== 5'h03 || busy !== 1'b1) begin errors++; $display("FAIL timeout_early: err %b opmode %h busy %b expected 0 03 1", err_timeout, opmode, busy); end
        tick;
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b expected 1", err_timeout); end
        checks++; if (opmode !== 5'd0 || input_data !== 352'd0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_zero: opmode %h busy %b expected 00 0", opmode, busy); end
        tick;
        tick;
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", err_timeout); end
        do_reset;
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_reset_clear: got %b expected 0", err_timeout); end
        push(5'h03, D_A);
        tick;
        tick;
        repeat (TIMEOUT - 1) tick;
        finished = 1'b1;
        tick;
        finished = 1'b0;
        checks++; if (err_timeout !== 1'b0 || opmode !== 5'd0) begin errors++; $display("FAIL timeout_finished_wins: err %b opmode %h expected 0 00", err_timeout, opmode); end
    endtask

    task test_continue;
        do_reset;
        push(5'h13, D_CONT);
        tick;
        checks++; if (opmode !== 5'h13) begin errors++; $display("FAIL cont_opmode: got %h expected 13", opmode); end
        checks++; if (input_data !== D_CONT) begin errors++; $display("FAIL cont_data: got %h expected %h", input_data, D_CONT); end
        for (int i = 0; i < 20; i++) begin
            tick;
            checks++; if (opmode !== 5'h13 || input_data !== D_CONT) begin errors++; $display("FAIL cont_stable_%0d: opmode %h data %h", i, opmode, input_data); end
        end
        finished = 1'b1;
        tick;
        finished = 1'b0;
        checks++; if (opmode !== 5'd0) begin errors++; $display("FAIL cont_done: got %h expected 00", opmode); end
    endtask

    task test_reset_mid_wait;
        do_reset;
        push(5'h03, D_A);
        tick;
        tick;
        push(5'h06, D_A);
        push(5'h03, D_A);
        checks++; if (level !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL midreset_setup: level %0d busy %b expected 2 1", level, busy); end
        reset = 1'b1;
        tick;
        checks++; if (opmode !== 5'd0) begin errors++; $display("FAIL midreset_opmode: got %h expected 00", opmode); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL midreset_level: got %0d expected 0", level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        repeat (8) tick;
        checks++; if (opmode !== 5'd0 || busy !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL midreset_after: opmode %h busy %b level %0d expected 00 0 0", opmode, busy, level); end
        checks++; if (err_timeout !== 1'b0 || err_illegal !== 1'b0) begin errors++; $display("FAIL midreset_errors: timeout %b illegal %b expected 0 0", err_timeout, err_illegal); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_illegal;
        test_timeout;
        test_continue;
        test_reset_mid_wait;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
